// File: rtl/mem_addr_reg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_addr_reg
//  Purpose  : 16-bit memory address register (MAR). Loaded byte-wise from the
//             8-bit CPU data bus, supports auto-increment / auto-decrement,
//             can return either address byte to the CPU bus, and decodes the
//             ROM/RAM region of the current address.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    RESET_ADDR : address value after reset
//    RAM_BASE   : first RAM address; lower addresses are ROM
//  Ports
//    clk      in     1   system clock, rising edge
//    resetn   in     1   asynchronous active-low reset
//    bus      inout  8   CPU data bus (tri-stated unless an output enable)
//    loadln   in     1   active-low, load bus into addr[7:0]
//    loadhn   in     1   active-low, load bus into addr[15:8]
//    incn     in     1   active-low, addr <= addr + 1
//    decn     in     1   active-low, addr <= addr - 1
//    outln    in     1   active-low, drive addr[7:0] onto bus
//    outhn    in     1   active-low, drive addr[15:8] onto bus
//    abus     out    16  current address to memory
//    ram_sel  out    1   1 when abus >= RAM_BASE
//    wrap     out    1   one-cycle pulse after inc/dec wrap-around
// ============================================================================
module mem_addr_reg #(
  parameter logic [15:0] RESET_ADDR = 16'h0000,
  parameter logic [15:0] RAM_BASE   = 16'h2000
) (
  input  logic        clk,
  input  logic        resetn,
  inout  wire  [7:0]  bus,
  input  logic        loadln,
  input  logic        loadhn,
  input  logic        incn,
  input  logic        decn,
  input  logic        outln,
  input  logic        outhn,
  output logic [15:0] abus,
  output logic        ram_sel,
  output logic        wrap
);

  localparam logic [15:0] c_ADDR_MAX = 16'hFFFF;
  localparam logic [15:0] c_ADDR_MIN = 16'h0000;

  logic [15:0] r_addr;
  logic        r_wrap;

  logic        w_load_lo;
  logic        w_load_hi;
  logic        w_any_load;
  logic        w_inc;
  logic        w_dec;
  logic        w_bus_oe;
  logic [7:0]  w_bus_out;
  logic [7:0]  w_bus_in;
  logic [15:0] w_addr_nxt;
  logic        w_wrap_nxt;

  // Control decode. Inc and dec asserted together cancel out.
  assign w_load_lo  = ~loadln;
  assign w_load_hi  = ~loadhn;
  assign w_any_load = w_load_lo | w_load_hi;
  assign w_inc      = ~incn & decn;
  assign w_dec      = ~decn & incn;

  // Bus output: low byte wins if both enables are asserted.
  assign w_bus_oe  = ~outln | ~outhn;
  assign w_bus_out = (~outln) ? r_addr[7:0] : r_addr[15:8];
  assign bus       = w_bus_oe ? w_bus_out : 8'bz;

  // When this block is driving the bus, a load in the same cycle captures the
  // value being driven (self-transfer). Taking it from the internal mux rather
  // than the resolved net keeps the loop purely combinational-free.
  assign w_bus_in = w_bus_oe ? w_bus_out : bus;

  always_comb begin
    w_addr_nxt = r_addr;
    w_wrap_nxt = 1'b0;
    if (w_any_load) begin
      if (w_load_lo) w_addr_nxt[7:0]  = w_bus_in;
      if (w_load_hi) w_addr_nxt[15:8] = w_bus_in;
    end else if (w_inc) begin
      w_addr_nxt = r_addr + 16'd1;
      w_wrap_nxt = (r_addr == c_ADDR_MAX);
    end else if (w_dec) begin
      w_addr_nxt = r_addr - 16'd1;
      w_wrap_nxt = (r_addr == c_ADDR_MIN);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr <= RESET_ADDR;
      r_wrap <= 1'b0;
    end else begin
      r_addr <= w_addr_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign abus    = r_addr;
  assign wrap    = r_wrap;
  assign ram_sel = (r_addr >= RAM_BASE);

endmodule
`default_nettype wire
